// File: rtl/fixed_to_float_seq.sv
// fixed_to_float_seq: sequential signed fixed-point (INT_W.FRAC_W, two's complement) to
// float {sign, exponent, mantissa} converter with start/done handshake.
// Normalisation shifts the magnitude left one bit per cycle. A final cycle then rounds
// (truncate or round-to-nearest-even) and saturates the result to infinity or signed zero.
//
// Ports:
//   clk       clock, all state updates on posedge
//   reset     asynchronous active-high reset
//   start     conversion request, accepted only when idle or done
//   rnd_mode  0 = truncate, 1 = round-to-nearest-even, sampled with start
//   din       fixed-point operand, sampled with start
//   dout      {sign, exponent, mantissa}, held stable while done
//   done      result valid, held until the next accepted start
//   busy      conversion in progress
//   ovf       result saturated to infinity
//   uf        result flushed to signed zero
module fixed_to_float_seq #(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8,
    parameter int EXP_W  = 5,
    parameter int MAN_W  = 10,
    parameter int BIAS   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    rnd_mode,
    input  logic [INT_W+FRAC_W-1:0] din,
    output logic [EXP_W+MAN_W:0]    dout,
    output logic                    done,
    output logic                    busy,
    output logic                    ovf,
    output logic                    uf
);

    localparam int W     = INT_W + FRAC_W;
    localparam int CNT_W = $clog2(W);
    // Index of the guard bit inside ext (ext = mag below the leading one, padded by two zeros)
    localparam int GB    = W - MAN_W;

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e               state_q, state_d;
    logic [W-1:0]         mag_q, mag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic                 rnd_q, rnd_d;
    logic [EXP_W+MAN_W:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 uf_q, uf_d;

    logic [W:0]           ext;
    logic [MAN_W-1:0]     m_trunc;
    logic                 guard;
    logic                 sticky;
    logic                 rnd_up;
    logic [MAN_W:0]       m_sum;
    logic [MAN_W-1:0]     m_fin;
    int                   e_v;

    // Rounding datapath, only meaningful once mag is normalised (ROUND state)
    always_comb begin
        ext     = {mag_q[W-2:0], 2'b00};
        m_trunc = ext[W -: MAN_W];
        guard   = ext[GB];
        sticky  = |ext[GB-1:0];
        rnd_up  = rnd_q & guard & (sticky | m_trunc[0]);
        m_sum   = {1'b0, m_trunc} + (MAN_W+1)'(rnd_up);
        e_v     = BIAS + INT_W - 1 - int'(cnt_q);
        m_fin   = m_sum[MAN_W-1:0];
        // Mantissa carry-out: value became 2.0, renormalise into the exponent
        if (m_sum[MAN_W]) begin
            m_fin = '0;
            e_v   = e_v + 1;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        uf_d    = uf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sign_d  = din[W-1];
                    // Most-negative input yields 2^(W-1), still representable unsigned
                    mag_d   = din[W-1] ? (~din + W'(1)) : din;
                    rnd_d   = rnd_mode;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    uf_d    = 1'b0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (mag_q == '0) begin
                    dout_d  = '0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (mag_q[W-1]) begin
                    state_d = StRound;
                end else begin
                    mag_d = {mag_q[W-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRound: begin
                if (e_v >= (1 << EXP_W) - 1) begin
                    dout_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_d  = 1'b1;
                end else if (e_v <= 0) begin
                    dout_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
                    uf_d   = 1'b1;
                end else begin
                    dout_d = {sign_q, e_v[EXP_W-1:0], m_fin};
                end
                done_d  = 1'b1;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mag_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            rnd_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            uf_q    <= uf_d;
        end
    end

    assign dout = dout_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign uf   = uf_q;
    assign busy = (state_q == StNorm) || (state_q == StRound);

endmodule
